// File: rtl/cnn_pkg.sv
// cnn_pkg -- constants and types shared by the image streaming front end.
//   IMG_W, IMG_H, NUM_PIX : default image geometry (28x28 = 784 pixels)
//   PIX_W, ADDR_W         : pixel width and frame-buffer address width
//   CLASS_W               : width of the CNN class index
//   TO_W                  : width of the WAIT timeout counter
//   tx_state_t            : states of the img_stream_tx controller
package cnn_pkg;

  localparam int IMG_W   = 28;
  localparam int IMG_H   = 28;
  localparam int NUM_PIX = IMG_W * IMG_H;
  localparam int PIX_W   = 8;
  localparam int ADDR_W  = 10;
  localparam int CLASS_W = 4;
  localparam int TO_W    = 16;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_STREAM = 2'd1,
    TX_WAIT   = 2'd2
  } tx_state_t;

endpackage

// File: rtl/img_stream_tx_if.sv
// img_stream_tx_if -- host / CNN facing signals of img_stream_tx.
//   host side : wr_en, wr_addr, wr_data, start -> block; busy, done, err, result <- block
//   CNN side  : pix_valid, pix_data -> CNN; class_valid, class_in <- CNN
//   modport master : the environment (host + CNN) driving the block
//   modport slave  : the img_stream_tx block itself
interface img_stream_tx_if;
  import cnn_pkg::*;

  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [PIX_W-1:0]   wr_data;
  logic               start;
  logic               busy;
  logic               pix_valid;
  logic [PIX_W-1:0]   pix_data;
  logic               class_valid;
  logic [CLASS_W-1:0] class_in;
  logic [CLASS_W-1:0] result;
  logic               done;
  logic               err;

  modport master (
    output wr_en, wr_addr, wr_data, start, class_valid, class_in,
    input  busy, pix_valid, pix_data, result, done, err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, class_valid, class_in,
    output busy, pix_valid, pix_data, result, done, err
  );

endinterface

// File: rtl/img_frame_ram.sv
// img_frame_ram -- simple dual-port frame buffer, DEPTH x DW, registered read.
//   clk, rst_n       : clock and synchronous active-low reset (read register only)
//   we, wr_addr/data : write port, caller guarantees wr_addr < DEPTH
//   re, rd_addr      : read enable / address; rd_data updates one edge later
//   rd_data          : read register, holds its value while re is low
// The memory array itself is never reset so that it maps onto block RAM and
// keeps the stored frame across a reset.
module img_frame_ram #(
  parameter int DEPTH = cnn_pkg::NUM_PIX,
  parameter int AW    = cnn_pkg::ADDR_W,
  parameter int DW    = cnn_pkg::PIX_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          re,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Output register reset maps onto the block-RAM output latch reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_reg <= '0;
    end else if (re) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/img_stream_tx.sv
// img_stream_tx -- stores one image from the host and streams it to the CNN,
// then waits for the classification result.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : img_stream_tx_if.slave (host writes/start, pixel stream,
//                class result, busy/done/err status)
// Parameters: IMG_W, IMG_H (geometry), TIMEOUT (max WAIT cycles before abort).
module img_stream_tx #(
  parameter int IMG_W   = cnn_pkg::IMG_W,
  parameter int IMG_H   = cnn_pkg::IMG_H,
  parameter int TIMEOUT = 65535
) (
  input  logic           clk,
  input  logic           rst_n,
  img_stream_tx_if.slave bus
);
  import cnn_pkg::*;

  localparam int                 N_PIX    = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0]  N_PIX_A  = ADDR_W'(N_PIX);
  localparam logic [ADDR_W-1:0]  LAST_PIX = ADDR_W'(N_PIX - 1);
  localparam logic [TO_W-1:0]    TO_LAST  = TO_W'(TIMEOUT - 1);

  tx_state_t          state_reg, state_next;
  logic [ADDR_W-1:0]  pix_cnt_reg, pix_cnt_next;
  logic [TO_W-1:0]    to_cnt_reg, to_cnt_next;
  logic               pix_valid_reg, pix_valid_next;
  logic               done_reg, done_next;
  logic               err_reg, err_next;
  logic [CLASS_W-1:0] result_reg, result_next;

  logic               ram_we;
  logic               ram_re;
  logic [ADDR_W-1:0]  ram_rd_addr;
  logic [PIX_W-1:0]   ram_rd_data;

  // Host writes only land while idle; a simultaneous start takes priority.
  assign ram_we = (state_reg == TX_IDLE) && !bus.start && bus.wr_en &&
                  (bus.wr_addr < N_PIX_A);

  img_frame_ram #(
    .DEPTH (N_PIX),
    .AW    (ADDR_W),
    .DW    (PIX_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (ram_we),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .re      (ram_re),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  // The RAM read is issued one edge ahead of the pixel it produces: the start
  // edge fetches pixel 0, and each STREAM edge with pix_cnt=k fetches k+1, so
  // the RAM output register doubles as the registered pix_data.
  always_comb begin
    state_next     = state_reg;
    pix_cnt_next   = pix_cnt_reg;
    to_cnt_next    = to_cnt_reg;
    pix_valid_next = pix_valid_reg;
    done_next      = 1'b0;
    err_next       = err_reg;
    result_next    = result_reg;
    ram_re         = 1'b0;
    ram_rd_addr    = '0;

    unique case (state_reg)
      TX_IDLE: begin
        if (bus.start) begin
          state_next     = TX_STREAM;
          pix_cnt_next   = '0;
          err_next       = 1'b0;
          pix_valid_next = 1'b1;
          ram_re         = 1'b1;
        end
      end

      TX_STREAM: begin
        if (pix_cnt_reg == LAST_PIX) begin
          state_next     = TX_WAIT;
          pix_valid_next = 1'b0;
          to_cnt_next    = '0;
        end else begin
          pix_cnt_next = pix_cnt_reg + 1'b1;
          ram_re       = 1'b1;
          ram_rd_addr  = pix_cnt_reg + 1'b1;
        end
      end

      TX_WAIT: begin
        // class_valid is checked first so it wins over a same-cycle timeout.
        if (bus.class_valid) begin
          result_next = bus.class_in;
          done_next   = 1'b1;
          state_next  = TX_IDLE;
        end else if (to_cnt_reg == TO_LAST) begin
          err_next   = 1'b1;
          done_next  = 1'b1;
          state_next = TX_IDLE;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= TX_IDLE;
      pix_cnt_reg   <= '0;
      to_cnt_reg    <= '0;
      pix_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      result_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      pix_cnt_reg   <= pix_cnt_next;
      to_cnt_reg    <= to_cnt_next;
      pix_valid_reg <= pix_valid_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      result_reg    <= result_next;
    end
  end

  assign bus.busy      = (state_reg != TX_IDLE);
  assign bus.pix_valid = pix_valid_reg;
  assign bus.pix_data  = ram_rd_data;
  assign bus.done      = done_reg;
  assign bus.err       = err_reg;
  assign bus.result    = result_reg;

endmodule

// File: tb/tb_img_stream_tx.sv
// tb_img_stream_tx -- self-checking bench for img_stream_tx.
// Two instances share one stimulus stream: dut0 with TIMEOUT=65535 and dut1
// with TIMEOUT=50, so both a late class result and the timeout path are seen
// in the same transaction.
module tb_img_stream_tx;
  import cnn_pkg::*;

  localparam int TO_A = 65535;
  localparam int TO_B = 50;
  localparam int NP   = NUM_PIX;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  img_stream_tx_if ifa();
  img_stream_tx_if ifb();

  assign ifb.wr_en       = ifa.wr_en;
  assign ifb.wr_addr     = ifa.wr_addr;
  assign ifb.wr_data     = ifa.wr_data;
  assign ifb.start       = ifa.start;
  assign ifb.class_valid = ifa.class_valid;
  assign ifb.class_in    = ifa.class_in;

  img_stream_tx #(.IMG_W(28), .IMG_H(28), .TIMEOUT(TO_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  img_stream_tx #(.IMG_W(28), .IMG_H(28), .TIMEOUT(TO_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: expected buffer contents and last result per DUT.
  logic [7:0] ref_mem [NP];
  logic [3:0] prev_res [2];
  int         to_of [2] = '{TO_A, TO_B};

  typedef struct {
    string      name;
    int         cv_wait;    // WAIT cycle (1-based) carrying class_valid
    logic [3:0] cls;
    int         noise_cyc;  // STREAM cycle with a stray class_valid, 0 = none
    logic [3:0] noise_cls;
    bit         inj;        // start + write to addr 5 during STREAM
    logic [3:0] exp_res_a;
    bit         exp_err_a;
    logic [3:0] exp_res_b;
    bit         exp_err_b;
  } vec_t;

  typedef struct {
    logic       busy;
    logic       pv;
    logic [7:0] pd;
    logic       done;
    logic       err;
    logic [3:0] res;
  } obs_t;

  vec_t vecs [6];

  function automatic obs_t get_obs(input int d);
    obs_t o;
    if (d == 0) begin
      o.busy = ifa.busy; o.pv = ifa.pix_valid; o.pd = ifa.pix_data;
      o.done = ifa.done; o.err = ifa.err; o.res = ifa.result;
    end else begin
      o.busy = ifb.busy; o.pv = ifb.pix_valid; o.pd = ifb.pix_data;
      o.done = ifb.done; o.err = ifb.err; o.res = ifb.result;
    end
    return o;
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d, expected %0d", name, d, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    obs_t o;
    for (int d = 0; d < 2; d++) begin
      o = get_obs(d);
      check({tag, ".busy"},      d, 32'(o.busy), 32'd0);
      check({tag, ".pix_valid"}, d, 32'(o.pv),   32'd0);
      check({tag, ".pix_data"},  d, 32'(o.pd),   32'd0);
      check({tag, ".done"},      d, 32'(o.done), 32'd0);
      check({tag, ".err"},       d, 32'(o.err),  32'd0);
      check({tag, ".result"},    d, 32'(o.res),  32'd0);
    end
  endtask

  // Entered and left at posedge+1 with idle inputs.
  task automatic write_pix(input int addr, input logic [7:0] data);
    ifa.wr_en = 1'b1; ifa.wr_addr = 10'(addr); ifa.wr_data = data;
    if (addr < NP) ref_mem[addr] = data;
    @(posedge clk); #1;
    ifa.wr_en = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int         limit;
    int         exp_done [2];
    int         n_valid [2], first_v [2], last_v [2], pix_bad [2];
    int         n_done [2], done_cyc [2];
    logic [3:0] res_done [2], exp_res [2];
    logic       err_done [2], busy1 [2], err1 [2], busy_done [2], exp_err [2];
    obs_t       o;
    exp_res[0] = v.exp_res_a; exp_err[0] = v.exp_err_a;
    exp_res[1] = v.exp_res_b; exp_err[1] = v.exp_err_b;
    for (int d = 0; d < 2; d++) begin
      n_valid[d] = 0; first_v[d] = -1; last_v[d] = -1; pix_bad[d] = 0;
      n_done[d] = 0; done_cyc[d] = -1; res_done[d] = 4'd0; err_done[d] = 1'b0;
      busy1[d] = 1'b0; err1[d] = 1'b1; busy_done[d] = 1'b1;
      exp_done[d] = NP + ((v.cv_wait <= to_of[d]) ? v.cv_wait : to_of[d]) + 1;
    end
    limit = NP + ((v.cv_wait > TO_B) ? v.cv_wait : TO_B) + 12;
    // Cycle 0: start, with a competing write that start must override.
    ifa.start = 1'b1; ifa.wr_en = 1'b1; ifa.wr_addr = 10'd7;
    ifa.wr_data = ~ref_mem[7]; ifa.class_valid = 1'b0;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      ifa.start       = v.inj && (cyc == 400);
      ifa.wr_en       = v.inj && (cyc == 400);
      ifa.wr_addr     = 10'd5;
      ifa.wr_data     = 8'hAA;
      ifa.class_valid = (cyc == NP + v.cv_wait) || (v.noise_cyc > 0 && cyc == v.noise_cyc);
      ifa.class_in    = (cyc == v.noise_cyc) ? v.noise_cls : v.cls;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        o = get_obs(d);
        if (o.pv === 1'b1) begin
          if (first_v[d] < 0) first_v[d] = cyc;
          last_v[d] = cyc;
          if (n_valid[d] < NP && o.pd !== ref_mem[n_valid[d]]) pix_bad[d]++;
          n_valid[d]++;
        end
        if (cyc == 1) begin busy1[d] = o.busy; err1[d] = o.err; end
        if (o.done === 1'b1) begin
          n_done[d]++;
          if (done_cyc[d] < 0) begin
            done_cyc[d] = cyc; res_done[d] = o.res; err_done[d] = o.err; busy_done[d] = o.busy;
          end
        end
      end
      @(posedge clk); #1;
    end
    ifa.start = 1'b0; ifa.wr_en = 1'b0; ifa.class_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check({v.name, ".stream_first"}, d, 32'(first_v[d]),  32'd1);
      check({v.name, ".stream_len"},   d, 32'(n_valid[d]),  32'(NP));
      check({v.name, ".stream_last"},  d, 32'(last_v[d]),   32'(NP));
      check({v.name, ".pix_bad"},      d, 32'(pix_bad[d]),  32'd0);
      check({v.name, ".busy_cyc1"},    d, 32'(busy1[d]),    32'd1);
      check({v.name, ".err_cyc1"},     d, 32'(err1[d]),     32'd0);
      check({v.name, ".done_count"},   d, 32'(n_done[d]),   32'd1);
      check({v.name, ".done_cycle"},   d, 32'(done_cyc[d]), 32'(exp_done[d]));
      check({v.name, ".result"},       d, 32'(res_done[d]), 32'(exp_res[d]));
      check({v.name, ".err"},          d, 32'(err_done[d]), 32'(exp_err[d]));
      check({v.name, ".busy_at_done"}, d, 32'(busy_done[d]), 32'd0);
      prev_res[d] = exp_res[d];
    end
    $display("txn %s: wait=%0d cls=%0d done@%0d/%0d res=%0d/%0d err=%0d/%0d",
             v.name, v.cv_wait, v.cls, done_cyc[0], done_cyc[1],
             res_done[0], res_done[1], err_done[0], err_done[1]);
  endtask

  // Reset in the middle of a stream: no done, immediate idle.
  task automatic reset_abort();
    obs_t o;
    int   n_pv, n_dn;
    n_pv = 0; n_dn = 0;
    ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    repeat (300) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset("mid_stream_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        o = get_obs(d);
        if (o.pv !== 1'b0) n_pv++;
        if (o.done !== 1'b0) n_dn++;
      end
      @(posedge clk); #1;
    end
    check("after_reset.pix_valid_cycles", 0, 32'(n_pv), 32'd0);
    check("after_reset.done_cycles",      0, 32'(n_dn), 32'd0);
    prev_res[0] = 4'd0; prev_res[1] = 4'd0;
    $display("txn reset_abort: reset at pixel 300, idle cycles observed");
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0;
    ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0;
    ifa.start = 1'b0; ifa.class_valid = 1'b0; ifa.class_in = '0;
    prev_res[0] = 4'd0; prev_res[1] = 4'd0;

    //          name          wait cls   noise  ncls   inj   resA  errA  resB  errB
    vecs[0] = '{"w100_cls7",  100, 4'd7, 0,   4'd0, 1'b0, 4'd7, 1'b0, 4'd0, 1'b1};
    vecs[1] = '{"w50_cls3",    50, 4'd3, 300, 4'd9, 1'b0, 4'd3, 1'b0, 4'd3, 1'b0};
    vecs[2] = '{"w20_inject",  20, 4'd5, 0,   4'd0, 1'b1, 4'd5, 1'b0, 4'd5, 1'b0};
    vecs[3] = '{"w1_cls9",      1, 4'd9, 0,   4'd0, 1'b0, 4'd9, 1'b0, 4'd9, 1'b0};
    vecs[4] = '{"w49_cls2",    49, 4'd2, 0,   4'd0, 1'b0, 4'd2, 1'b0, 4'd2, 1'b0};
    vecs[5] = '{"w51_cls4",    51, 4'd4, 0,   4'd0, 1'b0, 4'd4, 1'b0, 4'd2, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < NP; i++) write_pix(i, 8'(i % 256));

    for (int t = 0; t < 6; t++) begin
      if (t == 2) write_pix(900, 8'h11);
      run_txn(vecs[t]);
    end

    reset_abort();
    v = '{"after_reset", 10, 4'd6, 0, 4'd0, 1'b0, 4'd6, 1'b0, 4'd6, 1'b0};
    run_txn(v);

    for (int r = 0; r < 5; r++) begin
      repeat (16) write_pix(int'($urandom_range(0, 1023)), 8'($urandom_range(0, 255)));
      v.name      = $sformatf("rand%0d", r);
      v.cv_wait   = int'($urandom_range(1, 120));
      v.cls       = 4'($urandom_range(0, 9));
      v.noise_cyc = int'($urandom_range(1, NP));
      v.noise_cls = 4'($urandom_range(0, 9));
      v.inj       = 1'($urandom_range(0, 1));
      v.exp_res_a = (v.cv_wait <= TO_A) ? v.cls : prev_res[0];
      v.exp_err_a = (v.cv_wait > TO_A);
      v.exp_res_b = (v.cv_wait <= TO_B) ? v.cls : prev_res[1];
      v.exp_err_b = (v.cv_wait > TO_B);
      run_txn(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/img_stream_tx.md
IMG_STREAM_TX -- requirements
Module: img_stream_tx

Interface
REQ-001 The block SHALL have parameter IMG_W, default 28, meaning image width in pixels.
REQ-002 The block SHALL have parameter IMG_H, default 28, meaning image height in pixels; NUM_PIX = IMG_W*IMG_H (784).
REQ-003 The block SHALL have parameter TIMEOUT, default 65535, meaning maximum WAIT cycles before abort.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 wr_en  input  1  host frame-buffer write strobe.
REQ-007 wr_addr  input  10  pixel address, raster order, 0..NUM_PIX-1.
REQ-008 wr_data  input  8  pixel value, unsigned.
REQ-009 start  input  1  one-cycle request to stream the stored frame.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 pix_valid  output  1  pixel strobe to the CNN's in_valid.
REQ-012 pix_data  output  8  pixel to the CNN's in_data.
REQ-013 class_valid  input  1  classification-valid strobe from the CNN.
REQ-014 class_in  input  4  class index from the CNN, 0..9.
REQ-015 result  output  4  last latched class index.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 err  output  1  timeout flag, sticky until next accepted start.

Function
REQ-018 FSM states SHALL be IDLE, STREAM, WAIT, with DONE folded into a one-cycle done pulse on return to IDLE.
REQ-019 IDLE: wr_en with wr_addr < NUM_PIX SHALL write wr_data at the edge; wr_addr >= NUM_PIX SHALL be ignored.
REQ-020 Writes SHALL be ignored when busy is high, and when start is sampled high in the same cycle (start wins).
REQ-021 IDLE with start sampled high at edge T SHALL enter STREAM, clear err, and reset the pixel counter to 0.
REQ-022 Starting the cycle after T, pix_valid SHALL be high for exactly NUM_PIX consecutive cycles with pix_data = buffer[0..NUM_PIX-1] in order, registered, with no gaps.
REQ-023 pix_data SHALL hold its last value when pix_valid is low; its value then is don't-care for the sink.
REQ-024 After the cycle carrying pixel NUM_PIX-1, pix_valid SHALL drop and the FSM SHALL enter WAIT with the timeout counter at 0.
REQ-025 class_valid SHALL be ignored in IDLE and STREAM.
REQ-026 WAIT with class_valid high SHALL latch class_in into result, assert done for exactly one cycle, and enter IDLE.
REQ-027 WAIT SHALL increment the timeout counter each cycle; on reaching TIMEOUT without class_valid it SHALL set err, pulse done, leave result unchanged, and enter IDLE.
REQ-028 If class_valid arrives in the same cycle the counter reaches TIMEOUT, class_valid SHALL win and err SHALL stay 0.
REQ-029 start while busy SHALL be ignored, and start SHALL NOT be queued.
REQ-030 The pixel counter SHALL be 10 bits and the timeout counter 16 bits, and neither SHALL wrap within a transaction.

Reset
REQ-031 rst_n low at an edge SHALL force IDLE, with busy=0, pix_valid=0, pix_data=0, done=0, err=0, result=0, and all counters 0.
REQ-032 Reset asserted mid-STREAM or mid-WAIT SHALL abort the transaction immediately, with no done pulse and pix_valid low from the next edge.
REQ-033 Frame-buffer contents SHALL NOT be cleared by reset.

Structure
REQ-034 Shared package cnn_pkg SHALL hold IMG_W, IMG_H, NUM_PIX, the class-index width (4), and the tx FSM state enum.
REQ-035 The frame buffer SHALL be a sub-module img_frame_ram (1 write port, 1 read port, NUM_PIX x 8), sized for block-RAM inference.

Verification
REQ-036 Write buffer[i] = i mod 256 for all 784 addresses, then start -> pix_valid high exactly 784 consecutive cycles beginning one cycle after start, with pix_data sequence 0,1,…,255,0,…,15.
REQ-037 After streaming, drive class_valid with class_in=7 in WAIT cycle 100 -> result=7, done high for one cycle, err=0, busy low next cycle.
REQ-038 With TIMEOUT=50, never assert class_valid -> err=1 and done pulse in WAIT cycle 50, result keeps its previous value, and the next start clears err.
REQ-039 Pulse start and wr_en (addr 5, data 0xAA) during STREAM, plus a write to addr 900 in IDLE -> stream unaffected, buffer[5] unchanged, no second transaction.
REQ-040 Assert rst_n=0 at pixel 300 -> pix_valid=0, busy=0, no done; a restart then streams the original buffer contents intact.
REQ-041 Assert class_valid=1 (class_in=3) during STREAM and again in the same cycle the counter reaches TIMEOUT -> the first is ignored; the second yields result=3, err=0.
